mips_intc: RTL and testbench

Interrupt controller that sits directly upstream of the 5-stage MIPS core and drives its `interrupt` input. It collects up to IRQ_NUM peripheral request lines, detects rising edges, and latches them as pending. It applies a software mask and holds a single request to the core until the core acknowledges it. Software reads and clears state through a small register port mapped onto the data-memory bus.

---
 rtl/mips_intc_pkg.sv | 19 +
 rtl/mips_intc_sync.sv | 20 ++
 rtl/mips_intc.sv | 105 ++++++++++
 tb/tb_mips_intc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_intc_pkg.sv
// mips_intc_pkg: register offsets, FSM encoding, CAUSE layout and priority helper for mips_intc.
package mips_intc_pkg;
    localparam logic [1:0] INTC_PENDING = 2'd0;
    localparam logic [1:0] INTC_MASK    = 2'd1;
    localparam logic [1:0] INTC_CAUSE   = 2'd2;
    localparam logic [1:0] INTC_SWSET   = 2'd3;
    localparam int CAUSE_VALID = 31;
    localparam int CAUSE_ID_W  = 5;
    typedef enum logic [1:0] {
        INTC_IDLE    = 2'd0,
        INTC_REQ     = 2'd1,
        INTC_SERVICE = 2'd2
    } intc_state_e;
    function automatic logic [CAUSE_ID_W-1:0] lowest_id(input logic [31:0] v);
        lowest_id = '0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) lowest_id = i[CAUSE_ID_W-1:0];
    endfunction
endpackage

// File: rtl/mips_intc_sync.sv
// intc_sync: W-bit two-flop synchronizer with synchronous active-low reset.
module intc_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/mips_intc.sv
// mips_intc: edge-triggered interrupt controller feeding the MIPS core interrupt input.
// Define INTC_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module mips_intc
    import mips_intc_pkg::*;
#(
    parameter int          IRQ_NUM  = 8,
    parameter logic [31:0] MASK_RST = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq_in,
    input  logic               ir,
    output logic               interrupt,
    input  logic               reg_ren,
    input  logic               reg_wen,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_din,
    output logic [31:0]        reg_dout
);
    logic [IRQ_NUM-1:0]    s, s_d_q, edg, pend_q, pend_d, mask_q, active, set, clr;
    logic [CAUSE_ID_W-1:0] cause_id_q, win;
    logic [31:0]           rdata;
    logic [1:0]            arm_q;
    logic                  armed, ir_q, ir_rise, ir_fall, ack, cause_valid_q, unused_din;
    intc_state_e           state_q;

`ifdef INTC_SYNC_EN
    localparam logic [1:0] ARM_N = 2'd3;
    intc_sync #(.W(IRQ_NUM)) u_sync (.clk(clk), .rst(rst), .d_i(irq_in), .q_o(s));
`else
    localparam logic [1:0] ARM_N = 2'd1;
    assign s = irq_in;
`endif

    // Edges are ignored until the input pipeline has refilled after reset, so a level held through reset is not an event.
    assign armed      = arm_q == ARM_N;
    assign edg        = armed ? s & ~s_d_q : '0;
    assign active     = pend_q & mask_q;
    assign ir_rise    = ir & ~ir_q;
    assign ir_fall    = ~ir & ir_q;
    assign win        = lowest_id(32'(active));
    assign ack        = state_q == INTC_REQ && ir_rise && |active;
    assign unused_din = ^reg_din[31:IRQ_NUM];

    always_comb begin
        set    = edg | (reg_wen && reg_addr == INTC_SWSET ? reg_din[IRQ_NUM-1:0] : '0);
        clr    = (reg_wen && reg_addr == INTC_PENDING ? reg_din[IRQ_NUM-1:0] : '0) | (ack ? IRQ_NUM'(1) << win : '0);
        pend_d = (pend_q & ~clr) | set;
        rdata  = reg_addr == INTC_PENDING ? 32'(pend_q) :
                 reg_addr == INTC_MASK    ? 32'(mask_q) :
                 reg_addr == INTC_CAUSE   ? 32'(cause_id_q) | (32'(cause_valid_q) << CAUSE_VALID) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_d_q    <= '0;
            arm_q    <= '0;
            ir_q     <= 1'b0;
            pend_q   <= '0;
            mask_q   <= MASK_RST[IRQ_NUM-1:0];
            reg_dout <= '0;
        end else begin
            s_d_q  <= s;
            arm_q  <= armed ? arm_q : arm_q + 2'd1;
            ir_q   <= ir;
            pend_q <= pend_d;
            if (reg_wen && reg_addr == INTC_MASK) mask_q <= reg_din[IRQ_NUM-1:0];
            if (reg_ren) reg_dout <= rdata;
        end
    end

    // interrupt is loaded with the same decision as the next state, so it is high exactly in REQ.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= INTC_IDLE;
            interrupt     <= 1'b0;
            cause_valid_q <= 1'b0;
            cause_id_q    <= '0;
        end else begin
            case (state_q)
                INTC_IDLE: if (|active) begin
                    state_q   <= INTC_REQ;
                    interrupt <= 1'b1;
                end
                INTC_REQ: if (ack) begin
                    state_q       <= INTC_SERVICE;
                    interrupt     <= 1'b0;
                    cause_valid_q <= 1'b1;
                    cause_id_q    <= win;
                end else if (!(|active)) begin
                    state_q   <= INTC_IDLE;
                    interrupt <= 1'b0;
                end
                INTC_SERVICE: if (ir_fall) begin
                    state_q       <= INTC_IDLE;
                    cause_valid_q <= 1'b0;
                end
                default: begin
                    state_q   <= INTC_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_intc.sv
// tb_mips_intc: directed plus random stimulus for mips_intc, checked against a cycle-level reference model.
module tb_mips_intc;
    localparam int          N   = 8;
    localparam logic [31:0] ALL = 32'hFF;
`ifdef INTC_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic        clk = 1'b0, rst = 1'b0, ir = 1'b0, reg_ren = 1'b0, reg_wen = 1'b0;
    logic [7:0]  irq_in = '0;
    logic [1:0]  reg_addr = '0;
    logic [31:0] reg_din = '0;
    logic        interrupt;
    logic [31:0] reg_dout;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mips_intc #(.IRQ_NUM(N), .MASK_RST(32'hFF)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ir(ir), .interrupt(interrupt),
        .reg_ren(reg_ren), .reg_wen(reg_wen), .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout)
    );

    // Reference model: m_phase 0 = idle, 1 = requesting, 2 = in service; h[j] = irq_in sampled j edges ago.
    logic [31:0] m_pend = '0, m_mask = '0, m_cause = '0, m_dout = '0, m_act, m_clr, m_set, m_ev;
    logic [7:0]  h [4];
    logic        m_irp = 1'b0;
    int          m_phase = 0, since = 0, win;

    always @(posedge clk) begin
        if (!rst) begin
            m_pend = '0; m_mask = ALL; m_cause = '0; m_dout = '0; m_phase = 0; since = 0; m_irp = 1'b0;
            for (int j = 0; j < 4; j++) h[j] = '0;
        end else begin
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = irq_in;
            since++;
            m_ev  = since > D + 1 ? 32'(h[D] & ~h[D+1]) : '0;
            m_act = m_pend & m_mask;
            if (reg_ren) m_dout = reg_addr == 0 ? m_pend : reg_addr == 1 ? m_mask : reg_addr == 2 ? m_cause : '0;
            m_clr = (reg_wen && reg_addr == 0) ? reg_din : '0;
            m_set = m_ev | ((reg_wen && reg_addr == 3) ? reg_din : '0);
            if (m_phase == 1 && ir && !m_irp && m_act != 0) begin
                win = 0;
                for (int i = 7; i >= 0; i--) if (m_act[i]) win = i;
                m_clr   = m_clr | (32'd1 << win);
                m_cause = 32'h8000_0000 | 32'(win);
                m_phase = 2;
            end else if (m_phase == 1 && m_act == 0) m_phase = 0;
            else if (m_phase == 2 && !ir && m_irp) begin
                m_phase = 0;
                m_cause[31] = 1'b0;
            end else if (m_phase == 0 && m_act != 0) m_phase = 1;
            m_pend = ((m_pend & ~m_clr) | m_set) & ALL;
            if (reg_wen && reg_addr == 1) m_mask = reg_din & ALL;
            m_irp = ir;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("model_interrupt", 32'(interrupt), 32'(m_phase == 1));
        chk("model_reg_dout", reg_dout, m_dout);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        reg_ren = 1'b1; reg_addr = a;
        cyc();
        reg_ren = 1'b0;
        chk(tag, reg_dout, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_wen = 1'b1; reg_addr = a; reg_din = d;
        cyc();
        reg_wen = 1'b0;
    endtask

    initial begin
        wait_n(3);
        chk("rst_interrupt", 32'(interrupt), 0);
        chk("rst_dout", reg_dout, 0);
        rst = 1'b1;
        wait_n(D + 2);
        rd(1, 32'hFF, "rst_mask");
        rd(0, 32'h0, "rst_pending");
        rd(2, 32'h0, "rst_cause");

        irq_in[3] = 1'b1;
        for (int j = 0; j <= D; j++) begin
            cyc();
            chk("irq3_early", 32'(interrupt), 0);
        end
        cyc();
        chk("irq3_latency", 32'(interrupt), 1);
        irq_in = '0;
        rd(0, 32'h08, "irq3_pending");
        ir = 1'b1;
        cyc();
        chk("ack_drop", 32'(interrupt), 0);
        rd(2, 32'h8000_0003, "irq3_cause");
        rd(0, 32'h0, "irq3_ack_clear");
        ir = 1'b0;
        wait_n(2);

        irq_in = 8'h24;
        wait_n(D + 2);
        irq_in = '0;
        chk("two_req", 32'(interrupt), 1);
        ir = 1'b1;
        cyc();
        rd(2, 32'h8000_0002, "two_cause_lo");
        rd(0, 32'h20, "two_pending");
        ir = 1'b0;
        cyc();
        chk("eret_idle", 32'(interrupt), 0);
        cyc();
        chk("reraise", 32'(interrupt), 1);
        ir = 1'b1;
        cyc();
        rd(2, 32'h8000_0005, "two_cause_hi");
        ir = 1'b0;
        wait_n(2);
        chk("two_done", 32'(interrupt), 0);

        wr(1, 32'h0);
        irq_in = 8'h02;
        wait_n(D + 2);
        irq_in = '0;
        rd(0, 32'h02, "masked_pending");
        chk("masked_quiet", 32'(interrupt), 0);
        wr(1, 32'h02);
        chk("unmask_edge", 32'(interrupt), 0);
        cyc();
        chk("unmask_raise", 32'(interrupt), 1);
        wr(1, 32'hFF);
        wr(0, 32'h02);
        cyc();
        chk("w1c1_fall", 32'(interrupt), 0);
        wr(3, 32'h10);
        cyc();
        chk("swset_raise", 32'(interrupt), 1);
        wr(0, 32'h10);
        chk("w1c4_hold", 32'(interrupt), 1);
        cyc();
        chk("w1c4_fall", 32'(interrupt), 0);
        rd(0, 32'h0, "w1c4_pending");

        irq_in = 8'h01;
        wait_n(D);
        wr(0, 32'h01);
        irq_in = '0;
        rd(0, 32'h01, "set_beats_clear");
        wr(3, 32'h40);
        rd(0, 32'h41, "swset_pending");
        wr(0, 32'hFF);
        cyc();
        chk("cleared_idle", 32'(interrupt), 0);

        irq_in = 8'h80;
        wait_n(D + 2);
        chk("svc_req", 32'(interrupt), 1);
        ir = 1'b1;
        cyc();
        chk("svc_enter", 32'(interrupt), 0);
        rst = 1'b0; ir = 1'b0;
        cyc();
        chk("svc_rst_int", 32'(interrupt), 0);
        chk("svc_rst_dout", reg_dout, 0);
        cyc();
        rst = 1'b1;
        wait_n(D + 4);
        chk("held_no_int", 32'(interrupt), 0);
        rd(2, 32'h0, "svc_rst_cause");
        rd(0, 32'h0, "held_no_event");
        irq_in = '0;
        cyc();

        reg_ren = 1'b1; reg_wen = 1'b1; reg_addr = 2'd1; reg_din = 32'h5A;
        cyc();
        reg_ren = 1'b0; reg_wen = 1'b0;
        chk("rw_prewrite", reg_dout, 32'hFF);
        rd(1, 32'h5A, "rw_written");
        rd(3, 32'h0, "swset_reads0");
        wr(1, 32'hFF);

        for (int i = 0; i < 800; i++) begin
            irq_in   = irq_in ^ 8'($urandom & $urandom);
            if ($urandom_range(3) == 0) ir = ~ir;
            reg_ren  = $urandom_range(3) == 0;
            reg_wen  = $urandom_range(5) == 0;
            reg_addr = 2'($urandom);
            reg_din  = $urandom;
            rst      = $urandom_range(99) != 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
